// File: rtl/neuron_integrate_fire_256_pkg.sv
// Shared definitions for the integrate-and-fire neuron core: width defaults
// and the timestep sequencer state encoding.
package neuron_integrate_fire_256_pkg;

   localparam int NUM_NEURONS_DEF = 256;
   localparam int POT_W_DEF       = 16;
   localparam int WEIGHT_W_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FIRE    = 2'd1,
      PUBLISH = 2'd2
   } state_t;

endpackage

// File: rtl/neuron_integrate_fire_256_if.sv
// Connection-row input handshake and spike-vector output bundle of the
// neuron core; master is the upstream synapse path plus the spike router.
interface neuron_integrate_fire_256_if #(
   parameter int NUM_NEURONS = 256,
   parameter int WEIGHT_W    = 8
);

   logic                          conn_valid;
   logic                          conn_ready;
   logic [NUM_NEURONS-1:0]        connections;
   logic signed [WEIGHT_W-1:0]    weight;
   logic [NUM_NEURONS-1:0]        spikes;
   logic [$clog2(NUM_NEURONS):0]  spike_count;
   logic                          spikes_valid;

   modport master (
      output conn_valid, connections, weight,
      input  conn_ready, spikes, spike_count, spikes_valid
   );

   modport slave (
      input  conn_valid, connections, weight,
      output conn_ready, spikes, spike_count, spikes_valid
   );

endinterface

// File: rtl/neuron_integrate_fire_256_neuron_unit.sv
// One neuron: membrane potential register with saturating integrate,
// leak toward zero, threshold compare and post-spike reset.
module neuron_unit #(
   parameter int POT_W    = 16,
   parameter int WEIGHT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_add,
   input  logic                       en_fire,
   input  logic                       conn,
   input  logic signed [WEIGHT_W-1:0] weight,
   input  logic signed [POT_W-1:0]    threshold,
   input  logic signed [POT_W-1:0]    reset_pot,
   input  logic [POT_W-2:0]           leak,
   output logic                       spike
);

   localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
   localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

   logic signed [POT_W-1:0] pot;
   logic signed [POT_W-1:0] sum_sat;
   logic signed [POT_W-1:0] leaked;
   logic signed [POT_W:0]   pot_ext;
   logic signed [POT_W:0]   sum;
   logic signed [POT_W:0]   leak_ext;
   logic signed [POT_W:0]   mag;
   logic signed [POT_W:0]   step;

   always_comb begin
      pot_ext = {pot[POT_W-1], pot};
      sum     = pot_ext + {{(POT_W+1-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
      // top two bits disagree only when the widened sum left the POT_W range
      if (sum[POT_W] != sum[POT_W-1])
         sum_sat = sum[POT_W] ? POT_MIN : POT_MAX;
      else
         sum_sat = sum[POT_W-1:0];

      leak_ext = {2'b00, leak};
      mag      = pot[POT_W-1] ? -pot_ext : pot_ext;
      step     = (leak_ext < mag) ? leak_ext : mag;
      leaked   = POT_W'(pot[POT_W-1] ? pot_ext + step : pot_ext - step);
      spike    = (leaked >= threshold);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pot <= '0;
      else if (en_fire)
         pot <= spike ? reset_pot : leaked;
      else if (en_add && conn)
         pot <= sum_sat;
   end

endmodule

// File: rtl/neuron_integrate_fire_256.sv
// Integrate-and-fire neuron array: integrates connection rows, and on each
// timestep tick leaks, fires and publishes the spike vector with its count.
module neuron_integrate_fire_256
   import neuron_integrate_fire_256_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int POT_W       = POT_W_DEF,
   parameter int WEIGHT_W    = WEIGHT_W_DEF
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   neuron_integrate_fire_256_if.slave bus,
   input  logic                    tick_i,
   input  logic signed [POT_W-1:0] threshold_i,
   input  logic signed [POT_W-1:0] reset_pot_i,
   input  logic [POT_W-2:0]        leak_i,
   output logic                    busy_o
);

   localparam int CNT_W = $clog2(NUM_NEURONS) + 1;

   state_t                 state, next_state;
   logic                   tick_pending;
   logic                   en_add, en_fire;
   logic [NUM_NEURONS-1:0] spike_vec;
   logic [CNT_W-1:0]       spike_sum;

   for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
      neuron_unit #(
         .POT_W    (POT_W),
         .WEIGHT_W (WEIGHT_W)
      ) u_neuron (
         .clk       (wb_clk_i),
         .rst       (wb_rst_i),
         .en_add    (en_add),
         .en_fire   (en_fire),
         .conn      (bus.connections[n]),
         .weight    (bus.weight),
         .threshold (threshold_i),
         .reset_pot (reset_pot_i),
         .leak      (leak_i),
         .spike     (spike_vec[n])
      );
   end

   always_comb begin
      spike_sum = '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++)
         spike_sum = spike_sum + CNT_W'(spike_vec[i]);
   end

   always_comb begin
      next_state       = state;
      en_add           = 1'b0;
      en_fire          = 1'b0;
      bus.conn_ready   = 1'b0;
      bus.spikes_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.conn_ready = 1'b1;
            en_add         = bus.conn_valid;
            if (tick_i || tick_pending)
               next_state = FIRE;
         end
         FIRE: begin
            en_fire    = 1'b1;
            next_state = PUBLISH;
         end
         PUBLISH: begin
            bus.spikes_valid = 1'b1;
            next_state       = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // The count is registered alongside the vector so both are stable for the
   // whole PUBLISH cycle in which spikes_valid is asserted.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state           <= IDLE;
         tick_pending    <= 1'b0;
         bus.spikes      <= '0;
         bus.spike_count <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE)
            tick_pending <= 1'b0;
         else if (tick_i)
            tick_pending <= 1'b1;
         if (en_fire) begin
            bus.spikes      <= spike_vec;
            bus.spike_count <= spike_sum;
         end
      end
   end

   assign busy_o = (state != IDLE) || tick_pending;

endmodule

// File: tb/tb_neuron_integrate_fire_256.sv
// Scoreboard bench: each tick pushes the expected spike vector/count, and an
// independent monitor checks every spikes_valid pulse against the queue.
module tb_neuron_integrate_fire_256;

   logic               clk = 1'b0;
   logic               rst;
   logic               tick;
   logic signed [15:0] threshold;
   logic signed [15:0] reset_pot;
   logic [14:0]        leak;
   logic               busy;

   neuron_integrate_fire_256_if bus ();

   neuron_integrate_fire_256 dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .bus         (bus.slave),
      .tick_i      (tick),
      .threshold_i (threshold),
      .reset_pot_i (reset_pot),
      .leak_i      (leak),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [255:0] spikes;
      logic [8:0]   count;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(string name, logic [255:0] act, logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // monitor: compares every publish against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.spikes_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL publish: unexpected spikes_valid, got spikes %h, expected no pulse", bus.spikes);
            end else begin
               e = sb.pop_front();
               chk_vec("spikes", bus.spikes, e.spikes);
               chk("spike_count", 32'(bus.spike_count), 32'(e.count));
            end
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic send_row(logic [255:0] row, logic signed [7:0] w);
      bus.conn_valid  = 1'b1;
      bus.connections = row;
      bus.weight      = w;
      @(posedge clk); #1;
      bus.conn_valid  = 1'b0;
   endtask

   task automatic do_tick(logic [255:0] sp, logic [8:0] cnt);
      sb.push_back({sp, cnt});
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
      chk("tick_latency", 32'(bus.spikes_valid), 1);
      @(posedge clk); #1;
   endtask

   logic [255:0] row;

   initial begin
      rst             = 1'b1;
      tick            = 1'b0;
      threshold       = 16'sd10;
      reset_pot       = 16'sd0;
      leak            = '0;
      bus.conn_valid  = 1'b0;
      bus.connections = '0;
      bus.weight      = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // reset state
      chk("rst_ready", 32'(bus.conn_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(bus.spikes_valid), 0);
      chk("rst_count", 32'(bus.spike_count), 0);
      chk_vec("rst_spikes", bus.spikes, '0);

      // integrate: +5 on neurons 0/255, then -3 on neuron 0
      row = '0; row[0] = 1'b1; row[255] = 1'b1;
      send_row(row, 8'sd5);
      send_row(256'(1), -8'sd3);
      chk("int_pot0", 32'(dut.g_neuron[0].u_neuron.pot), 2);
      chk("int_pot255", 32'(dut.g_neuron[255].u_neuron.pot), 5);
      do_tick('0, 9'd0);
      chk("int_pot0_after", 32'(dut.g_neuron[0].u_neuron.pot), 2);
      chk("int_pot255_after", 32'(dut.g_neuron[255].u_neuron.pot), 5);

      // fire: neuron 7 reaches 12, leaks to 11 >= 10
      leak = 15'd1;
      repeat (3) send_row(256'(1) << 7, 8'sd4);
      chk("fire_pot7_pre", 32'(dut.g_neuron[7].u_neuron.pot), 12);
      do_tick(256'(1) << 7, 9'd1);
      chk("fire_pot7", 32'(dut.g_neuron[7].u_neuron.pot), 0);
      chk("fire_pot0_leak", 32'(dut.g_neuron[0].u_neuron.pot), 1);
      chk("fire_pot255_leak", 32'(dut.g_neuron[255].u_neuron.pot), 4);

      // row and tick together, then a tick during PUBLISH
      leak = '0;
      sb.push_back({256'(1) << 3, 9'd1});
      sb.push_back({256'(0), 9'd0});
      bus.conn_valid  = 1'b1;
      bus.connections = 256'(1) << 3;
      bus.weight      = 8'sd10;
      tick            = 1'b1;
      @(posedge clk); #1;
      bus.conn_valid = 1'b0;
      tick           = 1'b0;
      chk("sim_fire_ready", 32'(bus.conn_ready), 0);
      chk("sim_fire_busy", 32'(busy), 1);
      @(posedge clk); #1;
      chk("sim_pub1_valid", 32'(bus.spikes_valid), 1);
      chk("sim_pub1_busy", 32'(busy), 1);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      chk("sim_pending_busy", 32'(busy), 1);
      chk("sim_pending_valid", 32'(bus.spikes_valid), 0);
      @(posedge clk); #1;
      chk("sim_fire2_busy", 32'(busy), 1);
      @(posedge clk); #1;
      chk("sim_pub2_valid", 32'(bus.spikes_valid), 1);
      chk("sim_pub2_busy", 32'(busy), 1);
      @(posedge clk); #1;
      chk("sim_idle_busy", 32'(busy), 0);
      chk("sim_pot3", 32'(dut.g_neuron[3].u_neuron.pot), 0);

      // backpressure: row held through FIRE/PUBLISH is taken once
      sb.push_back({256'(0), 9'd0});
      tick = 1'b1;
      @(posedge clk); #1;
      tick            = 1'b0;
      bus.conn_valid  = 1'b1;
      bus.connections = 256'(1) << 20;
      bus.weight      = 8'sd3;
      chk("bp_fire_ready", 32'(bus.conn_ready), 0);
      @(posedge clk); #1;
      chk("bp_pub_ready", 32'(bus.conn_ready), 0);
      @(posedge clk); #1;
      chk("bp_idle_ready", 32'(bus.conn_ready), 1);
      chk("bp_pot20_held", 32'(dut.g_neuron[20].u_neuron.pot), 0);
      @(posedge clk); #1;
      bus.conn_valid = 1'b0;
      chk("bp_pot20_once", 32'(dut.g_neuron[20].u_neuron.pot), 3);
      @(posedge clk); #1;
      chk("bp_pot20_stable", 32'(dut.g_neuron[20].u_neuron.pot), 3);

      // saturation at both rails, full-count publish, maximum leak
      repeat (300) send_row('1, 8'sd127);
      chk("sat_hi_pot0", 32'(dut.g_neuron[0].u_neuron.pot), 32767);
      chk("sat_hi_pot128", 32'(dut.g_neuron[128].u_neuron.pot), 32767);
      chk("sat_hi_pot255", 32'(dut.g_neuron[255].u_neuron.pot), 32767);
      threshold = 16'sd32767;
      do_tick('1, 9'd256);
      chk("sat_hi_reset", 32'(dut.g_neuron[128].u_neuron.pot), 0);
      repeat (300) send_row('1, -8'sd128);
      chk("sat_lo_pot0", 32'(dut.g_neuron[0].u_neuron.pot), -32768);
      chk("sat_lo_pot128", 32'(dut.g_neuron[128].u_neuron.pot), -32768);
      chk("sat_lo_pot255", 32'(dut.g_neuron[255].u_neuron.pot), -32768);
      threshold = -16'sd32767;
      do_tick('0, 9'd0);
      chk("sat_lo_hold", 32'(dut.g_neuron[0].u_neuron.pot), -32768);
      leak      = 15'h7fff;
      threshold = -16'sd1;
      reset_pot = -16'sd5;
      do_tick('1, 9'd256);
      chk("maxleak_pot255", 32'(dut.g_neuron[255].u_neuron.pot), -5);

      // reset asserted in FIRE: no publish, everything back to reset values
      threshold = 16'sd10;
      reset_pot = 16'sd0;
      leak      = '0;
      tick      = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      rst  = 1'b1;
      #1;
      chk_vec("midrst_spikes", bus.spikes, '0);
      chk("midrst_count", 32'(bus.spike_count), 0);
      chk("midrst_valid", 32'(bus.spikes_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_pot0", 32'(dut.g_neuron[0].u_neuron.pot), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_ready", 32'(bus.conn_ready), 1);
      chk("midrst_pot255", 32'(dut.g_neuron[255].u_neuron.pot), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
